// File: rtl/dma_reg_pkg.sv
// Shared types and helpers for the DMA controller register/arbiter slice.
// Holds the arbiter state encoding and the rotating priority encoder.
package dma_reg_pkg;

  localparam int NUM_DMA_CH = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_REQ,
    GRANT,
    RELEASE
  } arb_state_t;

  // Returns {valid, ch}; hi_ch is the highest-priority channel, the
  // rest follow in ascending order modulo 4.
  function automatic logic [2:0] rot_pri_enc(
    input logic [3:0] req,
    input logic [1:0] hi_ch
  );
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = hi_ch + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_dreq_sync.sv
// Multi-stage synchroniser for the raw DREQ pins.
// Clears to raw level 0 on reset.
module dma_dreq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];

  // Shift chain: stage 0 samples the pin, last stage feeds the core.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dma_priority_arbiter.sv
// Channel arbiter and bus-hold sequencer for the 4-channel DMA controller.
// Qualifies requests, handshakes HRQ/HLDA and grants one channel via DACK.
import dma_reg_pkg::*;

module dma_priority_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = NUM_DMA_CH
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] dreq,
  input  logic [3:0] sw_req,
  input  logic [3:0] mask,
  input  logic       dreq_sense,
  input  logic       dack_sense,
  input  logic       priority_type,
  input  logic       dma_en,
  input  logic       hlda,
  input  logic       svc_done,
  output logic       hrq,
  output logic [3:0] dack,
  output logic       grant_valid,
  output logic [1:0] grant_ch,
  output logic [3:0] req_status
);

  logic [3:0] dreq_s;
  logic [3:0] hw_req;
  logic [3:0] eff_req;
  logic [2:0] win;
  logic [3:0] dack_act;

  arb_state_t state_q, state_d;
  logic [1:0] grant_ch_q, grant_ch_d;
  logic [1:0] hi_q, hi_d;
  logic [3:0] req_status_q;

  dma_dreq_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .W           (NUM_CH)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RESET),
    .d_i   (dreq),
    .q_o   (dreq_s)
  );

  assign hw_req  = dreq_s ^ {4{dreq_sense}};
  assign eff_req = (hw_req & ~mask) | sw_req;
  assign win     = rot_pri_enc(eff_req, priority_type ? hi_q : 2'd0);

  // State, frozen winner, rotation pointer and status snapshot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      grant_ch_q   <= 2'd0;
      hi_q         <= 2'd0;
      req_status_q <= 4'h0;
    end else begin
      state_q      <= state_d;
      grant_ch_q   <= grant_ch_d;
      hi_q         <= hi_d;
      req_status_q <= hw_req | sw_req;
    end
  end

  // Next-state: hold handshake, single arbitration point on HLDA.
  always_comb begin
    state_d    = state_q;
    grant_ch_d = grant_ch_q;
    hi_d       = hi_q;
    unique case (state_q)
      IDLE: begin
        if (dma_en && (|eff_req)) state_d = HOLD_REQ;
      end
      HOLD_REQ: begin
        if (!dma_en) begin
          state_d = RELEASE;
        end else if (hlda) begin
          if (win[2]) begin
            state_d    = GRANT;
            grant_ch_d = win[1:0];
          end else begin
            state_d = RELEASE;
          end
        end
      end
      GRANT: begin
        if (svc_done) begin
          state_d = RELEASE;
          if (priority_type) hi_d = grant_ch_q + 2'd1;
        end else if (!hlda) begin
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (!hlda) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hrq         = (state_q == HOLD_REQ) || (state_q == GRANT);
  assign grant_valid = (state_q == GRANT);
  assign grant_ch    = grant_ch_q;
  assign req_status  = req_status_q;
  assign dack_act    = grant_valid ? (4'b0001 << grant_ch_q) : 4'b0000;
  assign dack        = dack_sense ? dack_act : ~dack_act;

  a_dack_onehot0: assert property (
    @(posedge CLK) disable iff (RESET) $onehot0(dack_act)
  );

  a_dack_granted: assert property (
    @(posedge CLK) disable iff (RESET) grant_valid |-> $onehot(dack_act)
  );

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter.
// Stimulus pushes expected grants; a monitor checks each grant as it appears.
module tb_dma_priority_arbiter;

  localparam int SYNC = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] dreq, sw_req, mask;
  logic       dreq_sense, dack_sense, priority_type, dma_en, hlda, svc_done;
  logic       hrq, grant_valid;
  logic [3:0] dack, req_status;
  logic [1:0] grant_ch;

  int checks   = 0;
  int failures = 0;
  int hi_m     = 0;

  typedef struct {
    logic [1:0] ch;
    logic [3:0] dk;
  } exp_t;

  exp_t expq[$];

  always #5 CLK = ~CLK;

  dma_priority_arbiter #(.SYNC_STAGES(SYNC), .NUM_CH(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .dreq          (dreq),
    .sw_req        (sw_req),
    .mask          (mask),
    .dreq_sense    (dreq_sense),
    .dack_sense    (dack_sense),
    .priority_type (priority_type),
    .dma_en        (dma_en),
    .hlda          (hlda),
    .svc_done      (svc_done),
    .hrq           (hrq),
    .dack          (dack),
    .grant_valid   (grant_valid),
    .grant_ch      (grant_ch),
    .req_status    (req_status)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  function automatic logic [3:0] m_eff();
    logic [3:0] hw;
    hw = dreq ^ {4{dreq_sense}};
    return (hw & ~mask) | sw_req;
  endfunction

  // Reference: walk the priority list from the highest channel down.
  function automatic int m_pick();
    logic [3:0] e;
    int top;
    e = m_eff();
    top = priority_type ? hi_m : 0;
    for (int r = 0; r < 4; r++)
      if (e[(top + r) % 4]) return (top + r) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_dack(int ch);
    logic [3:0] a;
    a = 4'b0000;
    if (ch >= 0) a[ch] = 1'b1;
    return dack_sense ? a : ~a;
  endfunction

  // Monitor: every rising grant must match the oldest expectation.
  logic gv_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET && grant_valid && !gv_prev) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: grant_ch=%0d dack=%0h, none required",
                 grant_ch, dack);
      end else begin
        e = expq.pop_front();
        chk("mon_grant_ch", 32'(grant_ch), 32'(e.ch));
        chk("mon_dack", 32'(dack), 32'(e.dk));
      end
    end
    gv_prev = grant_valid;
  end

  task automatic do_reset();
    RESET    = 1'b1;
    hlda     = 1'b0;
    svc_done = 1'b0;
    step(2);
    RESET = 1'b0;
    hi_m  = 0;
  endtask

  task automatic wait_hrq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (hrq) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL hrq_timeout: hrq=0 after 40 cycles, required 1");
    end
  endtask

  // One full bus-hold service; mode 0=normal 1=abort 2=svc+hlda fall
  // together. hold: 0 none, 1 mask granted ch, 2 drop dma_en.
  task automatic run_service(int mode, int hold, output int got);
    bit ok;
    int w;
    got = -1;
    wait_hrq(ok);
    if (!ok) return;
    step(SYNC + 1 + int'($urandom_range(0, 3)));
    hlda = 1'b1;
    w = m_pick();
    if (w >= 0) expq.push_back('{ch: 2'(w), dk: m_dack(w)});
    step();
    chk("grant_valid", 32'(grant_valid), 32'd1);
    chk("hrq_in_grant", 32'(hrq), 32'd1);
    got = int'(grant_ch);
    if (hold == 1 && w >= 0) mask[w] = 1'b1;
    if (hold == 2) dma_en = 1'b0;
    if (hold != 0) begin
      step(2);
      chk("grant_held", 32'(grant_valid), 32'd1);
    end
    if (mode == 1) begin
      hlda = 1'b0;
      step();
    end else begin
      svc_done = 1'b1;
      if (mode == 2) hlda = 1'b0;
      step();
      svc_done = 1'b0;
      if (priority_type && w >= 0) hi_m = (w + 1) % 4;
    end
    chk("rel_grant_valid", 32'(grant_valid), 32'd0);
    chk("rel_hrq", 32'(hrq), 32'd0);
    chk("rel_dack", 32'(dack), 32'(m_dack(-1)));
    dma_en = 1'b1;
    hlda   = 1'b0;
    step();
  endtask

  initial begin
    int got;
    bit ok;
    logic [3:0] e;

    dreq = 4'h0; sw_req = 4'h0; mask = 4'h0;
    dreq_sense = 1'b0; dack_sense = 1'b0; priority_type = 1'b0;
    dma_en = 1'b1; hlda = 1'b0; svc_done = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_hrq", 32'(hrq), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_ch", 32'(grant_ch), 32'd0);
    chk("rst_req_status", 32'(req_status), 32'd0);
    chk("rst_dack", 32'(dack), 32'hF);
    do_reset();

    // Fixed priority and pin-to-hrq latency.
    dreq = 4'b0110;
    for (int k = 1; k <= SYNC + 1; k++) begin
      step();
      chk("hrq_latency", 32'(hrq), (k == SYNC + 1) ? 32'd1 : 32'd0);
    end
    step(3);
    hlda = 1'b1;
    expq.push_back('{ch: 2'd1, dk: 4'b1101});
    step();
    chk("fixed_grant_valid", 32'(grant_valid), 32'd1);
    chk("fixed_grant_ch", 32'(grant_ch), 32'd1);
    svc_done = 1'b1;
    step();
    svc_done = 1'b0;
    chk("fixed_release_dack", 32'(dack), 32'hF);
    hlda = 1'b0;
    step(2);

    // Rotating priority, all channels requesting.
    dreq = 4'h0;
    do_reset();
    priority_type = 1'b1;
    dreq = 4'hF;
    for (int i = 0; i < 5; i++) begin
      run_service(0, 0, got);
      chk("rot_order", 32'(got), 32'(i % 4));
    end

    // Abort keeps the pointer where it was.
    do_reset();
    run_service(0, 0, got);
    run_service(0, 0, got);
    run_service(1, 0, got);
    chk("abort_grant", 32'(got), 32'd2);
    run_service(0, 0, got);
    chk("after_abort_grant", 32'(got), 32'd2);

    // Masked hardware requests versus software request.
    priority_type = 1'b0;
    mask = 4'hF;
    do_reset();
    step(8);
    chk("masked_no_hrq", 32'(hrq), 32'd0);
    chk("masked_req_status", 32'(req_status), 32'hF);
    sw_req = 4'b1000;
    run_service(0, 0, got);
    chk("sw_grant", 32'(got), 32'd3);
    chk("sw_req_status", 32'(req_status), 32'hF);
    sw_req = 4'h0;
    mask = 4'h0;

    // Inverted pin polarities.
    dreq_sense = 1'b1;
    dack_sense = 1'b1;
    dreq = 4'b1101;
    do_reset();
    run_service(0, 0, got);
    chk("pol_grant", 32'(got), 32'd1);
    dreq_sense = 1'b0;
    dack_sense = 1'b0;

    // Request withdrawn before HLDA, then dma_en drop in HOLD_REQ.
    dreq = 4'b0001;
    do_reset();
    wait_hrq(ok);
    dreq = 4'h0;
    step(SYNC + 1);
    hlda = 1'b1;
    step();
    chk("wd_grant_valid", 32'(grant_valid), 32'd0);
    chk("wd_hrq", 32'(hrq), 32'd0);
    chk("wd_dack", 32'(dack), 32'hF);
    hlda = 1'b0;
    step(3);
    chk("wd_idle_hrq", 32'(hrq), 32'd0);
    dreq = 4'b0001;
    wait_hrq(ok);
    dma_en = 1'b0;
    step();
    chk("en_drop_hrq", 32'(hrq), 32'd0);
    step(3);
    chk("en_off_hrq", 32'(hrq), 32'd0);
    dma_en = 1'b1;
    dreq = 4'h0;

    // Asynchronous reset in the middle of a grant.
    dreq = 4'b0100;
    do_reset();
    wait_hrq(ok);
    step(SYNC + 1);
    hlda = 1'b1;
    expq.push_back('{ch: 2'd2, dk: 4'b1011});
    step();
    chk("pre_rst_grant", 32'(grant_valid), 32'd1);
    #1 RESET = 1'b1;
    #1;
    chk("arst_hrq", 32'(hrq), 32'd0);
    chk("arst_grant_valid", 32'(grant_valid), 32'd0);
    chk("arst_grant_ch", 32'(grant_ch), 32'd0);
    chk("arst_req_status", 32'(req_status), 32'd0);
    chk("arst_dack", 32'(dack), 32'hF);
    hlda = 1'b0;
    step();
    RESET = 1'b0;
    hi_m = 0;

    // Randomized services against the reference model.
    for (int it = 0; it < 40; it++) begin
      do begin
        dreq          = 4'($urandom);
        sw_req        = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        mask          = 4'($urandom);
        dreq_sense    = 1'($urandom);
        dack_sense    = 1'($urandom);
        priority_type = 1'($urandom);
        e = m_eff();
      end while (e == 4'h0);
      run_service(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), got);
      step(SYNC + 1);
      chk("rand_req_status", 32'(req_status),
          32'((dreq ^ {4{dreq_sense}}) | sw_req));
    end

    step(4);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
